// File: rtl/waveform_gen_param.sv
// ---------------------------------------------------------------------------
// waveform_gen_param
//
// Multi-mode waveform generator driven by a trigger input. It can follow
// sig_in as a level, emit a one-shot pulse, run PWM gated by sig_in, or emit
// a counted burst of pulses. High/low lengths and the burst count are
// programmable at runtime and are latched when a sequence starts.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   enable     block enable; low forces IDLE and sig_out=0
//   sig_in     trigger / level input (same clock domain)
//   mode       0=FOLLOW, 1=ONESHOT, 2=PWM, 3=BURST
//   high_len   high-phase length in cycles (0 treated as 1)
//   low_len    low-phase length in cycles (0 treated as 1)
//   burst_cnt  pulses per burst (0 treated as 1)
//   sig_out    generated waveform, driven directly from a flop
//   busy       high while the sequencer is in HIGH or LOW
//   done       one-cycle pulse after a sequence completes
// ---------------------------------------------------------------------------
module waveform_gen_param #(
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned BURST_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic               sig_in,
   input  logic [1:0]         mode,
   input  logic [CNT_W-1:0]   high_len,
   input  logic [CNT_W-1:0]   low_len,
   input  logic [BURST_W-1:0] burst_cnt,
   output logic               sig_out,
   output logic               busy,
   output logic               done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      M_FOLLOW  = 2'd0,
      M_ONESHOT = 2'd1,
      M_PWM     = 2'd2,
      M_BURST   = 2'd3
   } mode_e;

   localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
   localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

   state_e               state_q,      state_d;
   mode_e                mode_q,       mode_d;
   logic [CNT_W-1:0]     high_q,       high_d;
   logic [CNT_W-1:0]     low_q,        low_d;
   logic [CNT_W-1:0]     phase_q,      phase_d;
   logic [BURST_W-1:0]   burst_left_q, burst_left_d;
   logic                 sig_dly_q,    sig_dly_d;
   logic                 sig_out_q,    sig_out_d;
   logic                 busy_q,       busy_d;
   logic                 done_q,       done_d;

   logic                 rise;
   mode_e                mode_live;
   logic [CNT_W-1:0]     high_eff;
   logic [CNT_W-1:0]     low_eff;
   logic [BURST_W-1:0]   burst_eff;

   always_comb begin
      mode_live = mode_e'(mode);
      high_eff  = (high_len  == '0) ? CNT_ONE   : high_len;
      low_eff   = (low_len   == '0) ? CNT_ONE   : low_len;
      burst_eff = (burst_cnt == '0) ? BURST_ONE : burst_cnt;
      // Edge history runs even while disabled so re-enabling with sig_in
      // already high does not look like a fresh rise.
      rise      = sig_in & ~sig_dly_q;

      state_d      = state_q;
      mode_d       = mode_q;
      high_d       = high_q;
      low_d        = low_q;
      phase_d      = phase_q;
      burst_left_d = burst_left_q;
      sig_dly_d    = sig_in;
      done_d       = 1'b0;

      if (!enable) begin
         state_d      = ST_IDLE;
         phase_d      = '0;
         burst_left_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (rise && (mode_live != M_FOLLOW)) begin
                  mode_d       = mode_live;
                  high_d       = high_eff;
                  low_d        = low_eff;
                  phase_d      = high_eff - CNT_ONE;
                  burst_left_d = burst_eff - BURST_ONE;
                  state_d      = ST_HIGH;
               end
            end
            ST_HIGH: begin
               if (phase_q == '0) begin
                  if (mode_q == M_ONESHOT) begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_LOW;
                     phase_d = low_q - CNT_ONE;
                  end
               end else begin
                  phase_d = phase_q - CNT_ONE;
               end
            end
            ST_LOW: begin
               if (phase_q == '0) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
                  // PWM samples the gate only at the period boundary, so a
                  // fall mid-period lets the current period finish.
                  if ((mode_q == M_PWM) && sig_in) begin
                     state_d = ST_HIGH;
                     phase_d = high_q - CNT_ONE;
                     done_d  = 1'b0;
                  end else if ((mode_q == M_BURST) && (burst_left_q != '0)) begin
                     state_d      = ST_HIGH;
                     phase_d      = high_q - CNT_ONE;
                     burst_left_d = burst_left_q - BURST_ONE;
                     done_d       = 1'b0;
                  end
               end else begin
                  phase_d = phase_q - CNT_ONE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      // Outputs are computed from the next state so they register together
      // with it; FOLLOW only applies while no sequence is active.
      if (!enable) begin
         sig_out_d = 1'b0;
      end else if (state_d == ST_IDLE) begin
         sig_out_d = (mode_live == M_FOLLOW) ? sig_in : 1'b0;
      end else begin
         sig_out_d = (state_d == ST_HIGH);
      end
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         mode_q       <= M_FOLLOW;
         high_q       <= '0;
         low_q        <= '0;
         phase_q      <= '0;
         burst_left_q <= '0;
         sig_dly_q    <= 1'b0;
         sig_out_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         high_q       <= high_d;
         low_q        <= low_d;
         phase_q      <= phase_d;
         burst_left_q <= burst_left_d;
         sig_dly_q    <= sig_dly_d;
         sig_out_q    <= sig_out_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign sig_out = sig_out_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule
